spatz_xif_mux: RTL and testbench
================================

# spatz_xif_mux

Multi-requester front-end for the Spatz vector unit. It merges `NrPorts` independent X-interface issue channels from scalar cores into the single issue channel of the Spatz controller, using round-robin arbitration. It records the originating port of every accepted write-back instruction in an in-order tag FIFO, and uses that FIFO to route each returned result to its originating core. It sits between the core cluster interconnect and the `spatz` top.

## Interface
- `NrPorts`, default 4: number of requester channels (≥1); `PortIdxW = max(1, $clog2(NrPorts))`.
- `TagDepth`, default 8: maximum number of outstanding write-back instructions (≥2, power of two).
- `ReqWidth`, default 64: flattened issue-request payload width.
- `RespWidth`, default 4: flattened issue-response payload width. Bit 0 is `writeback`.
- `ResWidth`, default 64: flattened result payload width.
- `clk_i  in  1  clock; all state is updated on the rising edge.`
- `rst_i  in  1  reset, synchronous and active-high.`
- `x_issue_valid_i  in  NrPorts  per-port issue valid.`
- `x_issue_ready_o  out  NrPorts  per-port issue ready.`
- `x_issue_req_i  in  NrPorts*ReqWidth  per-port request; port p occupies bits [p*ReqWidth +: ReqWidth].`
- `x_issue_resp_o  out  NrPorts*RespWidth  per-port response; carries valid data only on the granted port, zero on all other ports.`
- `x_issue_valid_o  out  1  merged issue valid toward the controller.`
- `x_issue_ready_i  in  1  controller issue ready.`
- `x_issue_req_o  out  ReqWidth  granted request payload.`
- `x_issue_resp_i  in  RespWidth  controller response; sampled in the accept cycle.`
- `x_result_valid_i  in  1  controller result valid.`
- `x_result_ready_o  out  1  result ready toward the controller.`
- `x_result_i  in  ResWidth  result payload.`
- `x_result_valid_o  out  NrPorts  per-port result valid.`
- `x_result_ready_i  in  NrPorts  per-port result ready.`
- `x_result_o  out  ResWidth  result payload, broadcast to all ports.`
- `outstanding_o  out  $clog2(TagDepth)+1  current tag-FIFO occupancy.`
- `err_o  out  1  sticky protocol-error flag.`

## Operation
- State:
  - round-robin pointer `rr_q`, width PortIdxW;
  - lock flag `lock_q` with held grant `lock_idx_q`;
  - tag FIFO of PortIdxW-bit entries, with read/write pointers and a count;
  - `err_q`.
- Grant selection:
  - When `lock_q` is set, grant = `lock_idx_q`.
  - Otherwise, grant = the first port with valid set, searching from `rr_q` upward with wrap at NrPorts.
- Issue path:
  - `x_issue_valid_o = |x_issue_valid_i & !fifo_full`.
  - Request and response are muxed or demuxed by the grant.
  - `x_issue_ready_o[grant] = x_issue_ready_i & !fifo_full`. All other ready bits are 0.
- Accept condition: `x_issue_valid_o & x_issue_ready_i`. On accept:
  - `rr_q <= grant+1`, wrapping to 0 after NrPorts-1;
  - `lock_q <= 0`;
  - if `x_issue_resp_i[0]` is set, push `grant` into the FIFO.
- Lock: when `x_issue_valid_o` is high but there is no accept, `lock_q <= 1` and `lock_idx_q <= grant`. The grant must not change until accept (X-interface valid-stability rule).
- Full FIFO: issue is suppressed whenever the FIFO is full. This is conservative: it applies even to non-write-back instructions and even when a pop occurs in the same cycle.
- Result path with FIFO non-empty (head = `h`):
  - `x_result_valid_o[h] = x_result_valid_i`, all other bits 0;
  - `x_result_ready_o = x_result_ready_i[h]`;
  - pop the head when `x_result_valid_i & x_result_ready_o`.
- Result path with FIFO empty:
  - `x_result_ready_o = 1`, so the result is drained;
  - all `x_result_valid_o` bits are 0;
  - if `x_result_valid_i` is set, `err_q <= 1`.
- Simultaneous push and pop: the count is unchanged and both pointers advance.
- `err_q` clears only on reset.

## Timing
- The issue path and the result path are purely combinational: zero-cycle latency, no added stage.
- The FIFO push is visible to the result path one cycle after accept. A result may therefore target an instruction accepted one cycle earlier, but never one accepted in the same cycle.
- Reset (`rst_i` high at a clock edge) takes effect at that edge:
  - `rr_q`, `lock_q`, FIFO pointers/count and `err_q` all become 0;
  - outstanding tags are discarded.
- While `rst_i` is high and after reset, all outputs derive from the reset state: `x_issue_valid_o` follows inputs gated by the empty FIFO; `x_result_valid_o = 0`; `outstanding_o = 0`; `err_o = 0`.

## Test plan
- Single issue: port 2 issues with writeback=1 and controller ready.
  - Accept in the same cycle; `outstanding_o = 1`; `rr_q = 3`.
  - Controller returns a result with data 0xABCD → `x_result_valid_o = 4'b0100`; `x_result_o = 0xABCD`; `outstanding_o = 0` after the handshake.
- Fairness: all four ports valid continuously, ready always high, writeback=0.
  - Grants follow the sequence 0,1,2,3,0,…; each port receives exactly 1 accept per 4 cycles.
- Lock: ports 1 and 3 valid, ready low for 3 cycles, then high.
  - Grant stays on port 1 throughout; port 1 is accepted in cycle 4; port 3 is accepted next.
- Ordering and full condition (TagDepth=8):
  - Eight writeback issues from ports 3,1,0,2,3,1,0,2 → the ninth issue is blocked (valid_o=0, `outstanding_o = 8`).
  - Results are routed in the order 3,1,0,2,…; `x_result_ready_i[h]` is held low for 2 cycles to confirm the stall.
- Error: `x_result_valid_i` is asserted with the FIFO empty.
  - `x_result_ready_o = 1`, no port valid, `err_o = 1` from the next cycle until reset.
- Reset mid-operation: 5 tags outstanding, then `rst_i` pulsed for 1 cycle.
  - `outstanding_o = 0`, `err_o = 0`, `rr_q = 0`; a following result raises `err_o`.

Source files
------------

// File: rtl/spatz_xif_mux.sv
// rtl/spatz_xif_mux.sv - round-robin merge of X-interface issue channels with in-order result routing
module spatz_xif_mux #(
    parameter int NrPorts   = 4,
    parameter int TagDepth  = 8,
    parameter int ReqWidth  = 64,
    parameter int RespWidth = 4,
    parameter int ResWidth  = 64,
    parameter int PortIdxW  = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,

    input  logic [NrPorts-1:0]             x_issue_valid_i,
    output logic [NrPorts-1:0]             x_issue_ready_o,
    input  logic [NrPorts*ReqWidth-1:0]    x_issue_req_i,
    output logic [NrPorts*RespWidth-1:0]   x_issue_resp_o,

    output logic                           x_issue_valid_o,
    input  logic                           x_issue_ready_i,
    output logic [ReqWidth-1:0]            x_issue_req_o,
    input  logic [RespWidth-1:0]           x_issue_resp_i,

    input  logic                           x_result_valid_i,
    output logic                           x_result_ready_o,
    input  logic [ResWidth-1:0]            x_result_i,

    output logic [NrPorts-1:0]             x_result_valid_o,
    input  logic [NrPorts-1:0]             x_result_ready_i,
    output logic [ResWidth-1:0]            x_result_o,

    output logic [$clog2(TagDepth):0]      outstanding_o,
    output logic                           err_o
);

    localparam int PtrW = $clog2(TagDepth);
    localparam int CntW = PtrW + 1;

    logic [PortIdxW-1:0] r_rr;
    logic                r_lock;
    logic [PortIdxW-1:0] r_lock_idx;
    logic [PortIdxW-1:0] r_tags [TagDepth];
    logic [PtrW-1:0]     r_wptr;
    logic [PtrW-1:0]     r_rptr;
    logic [CntW-1:0]     r_count;
    logic                r_err;

    logic [PortIdxW-1:0] w_rr_grant;
    logic [PortIdxW-1:0] w_cand;
    logic                w_found;
    logic [PortIdxW-1:0] w_grant;
    logic [PortIdxW-1:0] w_rr_next;
    logic [PortIdxW-1:0] w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;

    assign w_full  = (r_count == CntW'(TagDepth));
    assign w_empty = (r_count == '0);
    assign w_head  = r_tags[r_rptr];

    // Round-robin search starting at r_rr, wrapping at NrPorts.
    always_comb begin
        w_rr_grant = r_rr;
        w_found    = 1'b0;
        w_cand     = '0;
        for (int i = 0; i < NrPorts; i++) begin
            if ((int'(r_rr) + i) >= NrPorts) begin
                w_cand = PortIdxW'(int'(r_rr) + i - NrPorts);
            end else begin
                w_cand = PortIdxW'(int'(r_rr) + i);
            end
            if (!w_found && x_issue_valid_i[w_cand]) begin
                w_found    = 1'b1;
                w_rr_grant = w_cand;
            end
        end
    end

    // A pending offer keeps its port until accepted, so valid stays stable.
    assign w_grant   = r_lock ? r_lock_idx : w_rr_grant;
    assign w_rr_next = (w_grant == PortIdxW'(NrPorts - 1)) ? '0 : (w_grant + PortIdxW'(1));

    assign x_issue_valid_o = (|x_issue_valid_i) & ~w_full;
    assign w_accept        = x_issue_valid_o & x_issue_ready_i;
    assign w_push          = w_accept & x_issue_resp_i[0];

    always_comb begin
        x_issue_req_o   = '0;
        x_issue_resp_o  = '0;
        x_issue_ready_o = '0;
        for (int p = 0; p < NrPorts; p++) begin
            if (w_grant == PortIdxW'(p)) begin
                x_issue_req_o                         = x_issue_req_i[p*ReqWidth +: ReqWidth];
                x_issue_resp_o[p*RespWidth +: RespWidth] = x_issue_resp_i;
                x_issue_ready_o[p]                    = x_issue_ready_i & ~w_full;
            end
        end
    end

    // With no tag outstanding the result is drained and flagged as stray.
    always_comb begin
        x_result_valid_o = '0;
        x_result_ready_o = 1'b1;
        if (!w_empty) begin
            x_result_ready_o         = x_result_ready_i[w_head];
            x_result_valid_o[w_head] = x_result_valid_i;
        end
    end

    assign w_pop      = ~w_empty & x_result_valid_i & x_result_ready_o;
    assign x_result_o = x_result_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr       <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_rr   <= w_rr_next;
                r_lock <= 1'b0;
            end else if (x_issue_valid_o) begin
                r_lock     <= 1'b1;
                r_lock_idx <= w_grant;
            end

            if (w_push) begin
                r_wptr <= r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PtrW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase

            if (w_empty && x_result_valid_i) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push && !rst_i) begin
            r_tags[r_wptr] <= w_grant;
        end
    end

    assign outstanding_o = r_count;
    assign err_o         = r_err;

endmodule

// File: tb/tb_spatz_xif_mux.sv
// tb/tb_spatz_xif_mux.sv - scoreboard bench for spatz_xif_mux
module tb_spatz_xif_mux;
    localparam int NP  = 4;
    localparam int TD  = 8;
    localparam int RQW = 64;
    localparam int RSW = 4;
    localparam int RW  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     issue_valid_i;
    logic [NP-1:0]     issue_ready_o;
    logic [NP*RQW-1:0] issue_req_i;
    logic [NP*RSW-1:0] issue_resp_o;
    logic              issue_valid_o;
    logic              issue_ready_i;
    logic [RQW-1:0]    issue_req_o;
    logic [RSW-1:0]    issue_resp_i;
    logic              result_valid_i;
    logic              result_ready_o;
    logic [RW-1:0]     result_i;
    logic [NP-1:0]     result_valid_o;
    logic [NP-1:0]     result_ready_i;
    logic [RW-1:0]     result_o;
    logic [3:0]        outstanding;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];
    int grant_q[$];

    always #5 clk = ~clk;

    spatz_xif_mux #(
        .NrPorts(NP), .TagDepth(TD), .ReqWidth(RQW), .RespWidth(RSW), .ResWidth(RW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .x_issue_valid_i(issue_valid_i), .x_issue_ready_o(issue_ready_o),
        .x_issue_req_i(issue_req_i), .x_issue_resp_o(issue_resp_o),
        .x_issue_valid_o(issue_valid_o), .x_issue_ready_i(issue_ready_i),
        .x_issue_req_o(issue_req_o), .x_issue_resp_i(issue_resp_i),
        .x_result_valid_i(result_valid_i), .x_result_ready_o(result_ready_o),
        .x_result_i(result_i), .x_result_valid_o(result_valid_o),
        .x_result_ready_i(result_ready_i), .x_result_o(result_o),
        .outstanding_o(outstanding), .err_o(err)
    );

    function automatic logic [RQW-1:0] req_of(input int p);
        return 64'(p + 1) * 64'h0101_0101_0101_0101;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        issue_valid_i  = '0;
        issue_ready_i  = 1'b0;
        issue_resp_i   = '0;
        result_valid_i = 1'b0;
        result_ready_i = '0;
        result_i       = '0;
    endtask

    task automatic do_reset;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset;
        do_reset();
        #2;
        n_checks++;
        if (outstanding !== 4'd0) begin n_errors++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err got %b exp 0", err); end
        n_checks++;
        if (result_valid_o !== 4'b0000 || issue_valid_o !== 1'b0) begin
            n_errors++; $display("FAIL reset_valids got %b/%b exp 0000/0", result_valid_o, issue_valid_o);
        end
        n_checks++;
        if (result_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_result_ready got %b exp 1", result_ready_o); end
        tick();
    endtask

    task automatic test_single;
        int e;
        do_reset();
        issue_valid_i = 4'b0100;
        issue_ready_i = 1'b1;
        issue_resp_i  = 4'h1;
        exp_q.push_back(2);
        #2;
        n_checks++;
        if (issue_valid_o !== 1'b1 || issue_ready_o !== 4'b0100) begin
            n_errors++; $display("FAIL single_handshake got %b/%b exp 1/0100", issue_valid_o, issue_ready_o);
        end
        n_checks++;
        if (issue_req_o !== req_of(2)) begin n_errors++; $display("FAIL single_req got %h exp %h", issue_req_o, req_of(2)); end
        n_checks++;
        if (issue_resp_o !== 16'h0100) begin n_errors++; $display("FAIL single_resp got %h exp 0100", issue_resp_o); end
        tick();
        idle();
        n_checks++;
        if (outstanding !== 4'd1) begin n_errors++; $display("FAIL single_outstanding got %0d exp 1", outstanding); end
        // rr should now point at port 3
        issue_valid_i = 4'b1111;
        issue_ready_i = 1'b1;
        #2;
        n_checks++;
        if (issue_ready_o !== 4'b1000) begin n_errors++; $display("FAIL single_rr got %b exp 1000", issue_ready_o); end
        tick();
        idle();
        result_valid_i = 1'b1;
        result_i       = 64'hABCD;
        result_ready_i = 4'b1111;
        e = exp_q.pop_front();
        #2;
        n_checks++;
        if (result_valid_o !== 4'(1 << e) || result_o !== 64'hABCD || result_ready_o !== 1'b1) begin
            n_errors++; $display("FAIL single_result got %b/%h/%b exp %b/abcd/1", result_valid_o, result_o, result_ready_o, 4'(1 << e));
        end
        tick();
        idle();
        n_checks++;
        if (outstanding !== 4'd0 || err !== 1'b0) begin
            n_errors++; $display("FAIL single_drain got %0d/%b exp 0/0", outstanding, err);
        end
    endtask

    task automatic test_fairness;
        int cnt[NP];
        int g;
        do_reset();
        for (int p = 0; p < NP; p++) cnt[p] = 0;
        issue_valid_i = 4'b1111;
        issue_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            grant_q.push_back(c % NP);
            #2;
            g = grant_q.pop_front();
            n_checks++;
            if (issue_ready_o !== 4'(1 << g)) begin
                n_errors++; $display("FAIL fair_grant cycle %0d got %b exp %b", c, issue_ready_o, 4'(1 << g));
            end
            for (int p = 0; p < NP; p++) if (issue_ready_o[p]) cnt[p]++;
            tick();
        end
        idle();
        for (int p = 0; p < NP; p++) begin
            n_checks++;
            if (cnt[p] != 2) begin n_errors++; $display("FAIL fair_count port %0d got %0d exp 2", p, cnt[p]); end
        end
    endtask

    task automatic test_lock;
        do_reset();
        issue_valid_i = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) issue_valid_i = 4'b1011;
            #2;
            n_checks++;
            if (issue_req_o !== req_of(1) || issue_ready_o !== 4'b0000) begin
                n_errors++; $display("FAIL lock_hold cycle %0d got %h/%b exp %h/0000", c, issue_req_o, issue_ready_o, req_of(1));
            end
            tick();
        end
        issue_ready_i = 1'b1;
        #2;
        n_checks++;
        if (issue_ready_o !== 4'b0010) begin n_errors++; $display("FAIL lock_accept got %b exp 0010", issue_ready_o); end
        tick();
        issue_valid_i = 4'b1001;
        #2;
        n_checks++;
        if (issue_ready_o !== 4'b1000) begin n_errors++; $display("FAIL lock_next got %b exp 1000", issue_ready_o); end
        tick();
        idle();
    endtask

    task automatic test_full;
        int ord[8] = '{3, 1, 0, 2, 3, 1, 0, 2};
        int e;
        do_reset();
        issue_ready_i = 1'b1;
        issue_resp_i  = 4'h1;
        for (int k = 0; k < 8; k++) begin
            issue_valid_i = 4'(1 << ord[k]);
            exp_q.push_back(ord[k]);
            #2;
            n_checks++;
            if (issue_ready_o !== 4'(1 << ord[k])) begin
                n_errors++; $display("FAIL full_fill %0d got %b exp %b", k, issue_ready_o, 4'(1 << ord[k]));
            end
            tick();
        end
        issue_valid_i = 4'b0001;
        #2;
        n_checks++;
        if (issue_valid_o !== 1'b0 || issue_ready_o !== 4'b0000 || outstanding !== 4'd8) begin
            n_errors++; $display("FAIL full_block got %b/%b/%0d exp 0/0000/8", issue_valid_o, issue_ready_o, outstanding);
        end
        tick();
        idle();
        for (int k = 0; k < 8; k++) begin
            e = exp_q.pop_front();
            result_valid_i = 1'b1;
            result_i       = 64'h100 + 64'(k);
            if (k == 0) begin
                result_ready_i = ~4'(1 << e);
                repeat (2) begin
                    #2;
                    n_checks++;
                    if (result_ready_o !== 1'b0 || result_valid_o !== 4'(1 << e)) begin
                        n_errors++; $display("FAIL full_stall got %b/%b exp 0/%b", result_ready_o, result_valid_o, 4'(1 << e));
                    end
                    tick();
                    n_checks++;
                    if (outstanding !== 4'd8) begin n_errors++; $display("FAIL full_stall_cnt got %0d exp 8", outstanding); end
                end
            end
            result_ready_i = 4'b1111;
            #2;
            n_checks++;
            if (result_valid_o !== 4'(1 << e) || result_o !== 64'h100 + 64'(k) || result_ready_o !== 1'b1) begin
                n_errors++; $display("FAIL full_order %0d got %b/%h/%b exp %b/%h/1", k, result_valid_o, result_o, result_ready_o, 4'(1 << e), 64'h100 + 64'(k));
            end
            tick();
        end
        idle();
        n_checks++;
        if (outstanding !== 4'd0) begin n_errors++; $display("FAIL full_drain got %0d exp 0", outstanding); end
    endtask

    task automatic test_back_to_back;
        int e;
        do_reset();
        issue_valid_i  = 4'b0001;
        issue_ready_i  = 1'b1;
        issue_resp_i   = 4'h1;
        result_valid_i = 1'b1;
        result_ready_i = 4'b1111;
        exp_q.push_back(0);
        #2;
        n_checks++;
        if (result_valid_o !== 4'b0000) begin n_errors++; $display("FAIL b2b_same_cycle got %b exp 0000", result_valid_o); end
        tick();
        issue_valid_i = 4'b0010;
        exp_q.push_back(1);
        e = exp_q.pop_front();
        #2;
        n_checks++;
        if (result_valid_o !== 4'(1 << e)) begin n_errors++; $display("FAIL b2b_first got %b exp %b", result_valid_o, 4'(1 << e)); end
        tick();
        issue_valid_i = 4'b0000;
        n_checks++;
        if (outstanding !== 4'd1) begin n_errors++; $display("FAIL b2b_pushpop got %0d exp 1", outstanding); end
        e = exp_q.pop_front();
        #2;
        n_checks++;
        if (result_valid_o !== 4'(1 << e)) begin n_errors++; $display("FAIL b2b_second got %b exp %b", result_valid_o, 4'(1 << e)); end
        tick();
        idle();
        n_checks++;
        if (outstanding !== 4'd0) begin n_errors++; $display("FAIL b2b_drain got %0d exp 0", outstanding); end
    endtask

    task automatic test_error;
        do_reset();
        result_valid_i = 1'b1;
        result_i       = 64'hDEAD;
        #2;
        n_checks++;
        if (result_ready_o !== 1'b1 || result_valid_o !== 4'b0000 || err !== 1'b0) begin
            n_errors++; $display("FAIL err_drain got %b/%b/%b exp 1/0000/0", result_ready_o, result_valid_o, err);
        end
        tick();
        idle();
        n_checks++;
        if (err !== 1'b1) begin n_errors++; $display("FAIL err_set got %b exp 1", err); end
        repeat (3) tick();
        n_checks++;
        if (err !== 1'b1) begin n_errors++; $display("FAIL err_sticky got %b exp 1", err); end
    endtask

    task automatic test_reset_mid;
        issue_ready_i = 1'b1;
        issue_resp_i  = 4'h1;
        for (int k = 0; k < 5; k++) begin
            issue_valid_i = 4'(1 << (k % NP));
            exp_q.push_back(k % NP);
            tick();
        end
        idle();
        n_checks++;
        if (outstanding !== 4'd5 || err !== 1'b1) begin
            n_errors++; $display("FAIL mid_pre got %0d/%b exp 5/1", outstanding, err);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        n_checks++;
        if (outstanding !== 4'd0 || err !== 1'b0) begin
            n_errors++; $display("FAIL mid_post got %0d/%b exp 0/0", outstanding, err);
        end
        issue_valid_i = 4'b1111;
        #2;
        n_checks++;
        if (issue_req_o !== req_of(0)) begin n_errors++; $display("FAIL mid_rr got %h exp %h", issue_req_o, req_of(0)); end
        tick();
        idle();
        result_valid_i = 1'b1;
        #2;
        n_checks++;
        if (result_valid_o !== 4'b0000 || result_ready_o !== 1'b1) begin
            n_errors++; $display("FAIL mid_stray got %b/%b exp 0000/1", result_valid_o, result_ready_o);
        end
        tick();
        idle();
        n_checks++;
        if (err !== 1'b1) begin n_errors++; $display("FAIL mid_err got %b exp 1", err); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        for (int p = 0; p < NP; p++) issue_req_i[p*RQW +: RQW] = req_of(p);
        test_reset();
        test_single();
        test_fairness();
        test_lock();
        test_full();
        test_back_to_back();
        test_error();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
